// File: rtl/ucode_pkg.sv
// ucode_pkg: shared microword encodings, micro-address constants and sequencer state type
package ucode_pkg;
  localparam int UPC_W = 8;
  localparam int UPC_FETCH = 0;
  localparam int UPC_IRQ = 8;
  localparam int UPC_ILL = 12;
  localparam int USTACK_DEPTH = 4;
  typedef enum logic [2:0] {
    BT_NEXT = 3'd0,
    BT_JMP  = 3'd1,
    BT_BRT  = 3'd2,
    BT_BRF  = 3'd3,
    BT_DISP = 3'd4,
    BT_CALL = 3'd5,
    BT_RET  = 3'd6,
    BT_END  = 3'd7
  } bt_e;
  typedef enum logic {ST_RUN = 1'b0, ST_HALT = 1'b1} seq_state_e;
endpackage

// File: rtl/micro_stack.sv
// micro_stack: DEPTH x W LIFO holding micro-subroutine return addresses
module micro_stack #(
  parameter int DEPTH = 4,
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] top,
  output logic         full,
  output logic         empty
);
  localparam int PW = $clog2(DEPTH);
  logic [W-1:0] mem_q [DEPTH];
  logic [PW:0]  cnt_q;
  assign full  = cnt_q == (PW+1)'(DEPTH);
  assign empty = cnt_q == '0;
  assign top   = mem_q[cnt_q[PW-1:0] - PW'(1)];
  // occupancy counter; push on full and pop on empty are ignored
  always_ff @(posedge clk)
    if (rst) cnt_q <= '0;
    else if (push && !full) cnt_q <= cnt_q + (PW+1)'(1);
    else if (pop && !empty) cnt_q <= cnt_q - (PW+1)'(1);
  // entry storage needs no reset; it is only read below the occupancy count
  always_ff @(posedge clk)
    if (push && !full) mem_q[cnt_q[PW-1:0]] <= din;
endmodule

// File: rtl/micro_sequencer.sv
// micro_sequencer: micro-PC sequencer with branch mux, return stack, stalls, halt and irq entry
module micro_sequencer import ucode_pkg::*; #(
  parameter int AW = UPC_W,
  parameter int FETCH_ADDR = UPC_FETCH,
  parameter int IRQ_ADDR = UPC_IRQ,
  parameter int ILL_ADDR = UPC_ILL,
  parameter int STACK_DEPTH = USTACK_DEPTH
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [2:0]    bt,
  input  logic [3:0]    cond_sel,
  input  logic [AW-1:0] ba,
  input  logic          mem_wait,
  input  logic          mem_ready,
  input  logic [15:0]   cond,
  input  logic [AW-1:0] map_addr,
  input  logic          irq_pend,
  input  logic          halt_req,
  input  logic          start,
  output logic [AW-1:0] upc,
  output logic          stall,
  output logic          halted,
  output logic          irq_ack,
  output logic          ustack_err
);
  seq_state_e state_q;
  bt_e op;
  logic [AW-1:0] upc_q, upc_d, inc, top;
  logic irq_ack_q, err_q, full, empty, step, c, call, ret, push, pop, take_irq, err_hit;
  assign op       = bt_e'(bt);
  assign stall    = mem_wait & ~mem_ready;
  assign step     = (state_q == ST_RUN) & ~stall;
  assign c        = cond[cond_sel];
  assign inc      = upc_q + AW'(1);
  assign call     = op == BT_CALL;
  assign ret      = op == BT_RET;
  assign push     = step & call & ~full;
  assign pop      = step & ret & ~empty;
  assign take_irq = step & (op == BT_END) & irq_pend;
  assign err_hit  = step & ((call & full) | (ret & empty));
  // next micro-address selected by the branch type of the current microword
  always_comb
    upc_d = op == BT_NEXT ? inc :
            op == BT_JMP  ? ba :
            op == BT_BRT  ? (c ? ba : inc) :
            op == BT_BRF  ? (c ? inc : ba) :
            op == BT_DISP ? (map_addr != '0 ? map_addr : AW'(ILL_ADDR)) :
            op == BT_CALL ? ba :
            op == BT_RET  ? (empty ? AW'(FETCH_ADDR) : top) :
            irq_pend      ? AW'(IRQ_ADDR) : AW'(FETCH_ADDR);
  micro_stack #(.DEPTH(STACK_DEPTH), .W(AW)) u_stack (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (inc),
    .top   (top),
    .full  (full),
    .empty (empty)
  );
  // RUN/HALT control, micro-PC register and registered status flags
  always_ff @(posedge clk)
    if (rst) begin
      state_q   <= ST_RUN;
      upc_q     <= AW'(FETCH_ADDR);
      irq_ack_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      irq_ack_q <= take_irq;
      err_q     <= err_q | err_hit;
      if (state_q == ST_HALT) begin
        if (start) state_q <= ST_RUN;
      end else if (step) begin
        upc_q <= upc_d;
        if (halt_req) state_q <= ST_HALT;
      end
    end
  assign upc        = upc_q;
  assign halted     = state_q == ST_HALT;
  assign irq_ack    = irq_ack_q;
  assign ustack_err = err_q;
endmodule
